// File: rtl/dato_fifo.sv
// Show-ahead FIFO buffering the registered DATAO word; a push into an empty FIFO is visible one cycle later.
// Backpressure: DATAO_RDY pops the head; writes to a full FIFO without a same-cycle pop are dropped and counted.
module dato_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [WIDTH-1:0]         DATAI,
    input  logic                     DATAI_VLD,
    output logic [WIDTH-1:0]         DATAO,
    output logic                     DATAO_VLD,
    input  logic                     DATAO_RDY,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     OVF,
    output logic [7:0]               DROP_CNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q,  level_d;
    logic             ovf_q,    ovf_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic pop;
    logic push;
    logic drop;

    always_comb begin
        // A pop frees the slot being written, so a full FIFO still accepts a write when it also pops.
        pop  = (level_q != '0) && DATAO_RDY;
        push = DATAI_VLD && ((level_q != LVL_FULL) || pop);
        drop = DATAI_VLD && (level_q == LVL_FULL) && !pop;

        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;

        if (push) begin
            mem_d[wr_ptr_q] = DATAI;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (drop) begin
            ovf_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is not reset; the level/pointer state alone defines which entries are live.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    assign DATAO     = mem_q[rd_ptr_q];
    assign DATAO_VLD = (level_q != '0);
    assign EMPTY     = (level_q == '0);
    assign FULL      = (level_q == LVL_FULL);
    assign LEVEL     = level_q;
    assign OVF       = ovf_q;
    assign DROP_CNT  = drop_cnt_q;

endmodule
